// File: rtl/ad9228_serial_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ad9228_serial_tx                                                         |
// | Serializes parallel samples into AD9228-style LVDS-like frames           |
// | (dout MSB first, fco frame clock, dco bit clock) via a one-entry hold.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ad9228_serial_tx #(
    parameter int                    DATA_WIDTH   = 12,
    parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  dout,
    output logic                  fco,
    output logic                  dco,
    output logic                  frame_start,
    output logic                  busy,
    output logic [7:0]            underrun_cnt
);

    localparam int                CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]     LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]     HALF_M1  = CW'(DATA_WIDTH / 2 - 1);

    localparam logic [0:0]        S_IDLE   = 1'b0;
    localparam logic [0:0]        S_SEND   = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  dout_q, dout_d;
    logic                  fco_q, fco_d;
    logic                  dco_q, dco_d;
    logic                  frame_start_q, frame_start_d;
    logic                  busy_q, busy_d;
    logic [7:0]            underrun_q, underrun_d;

    logic                  last_bit;
    logic                  frame_load;
    logic                  accept;
    logic [DATA_WIDTH-1:0] next_frame;

    assign last_bit   = (bit_cnt_q == LAST_BIT);
    assign frame_load = en & ((state_q == S_IDLE) | ((state_q == S_SEND) & last_bit));
    // A full hold slot frees up on a load edge, so it can be refilled on that same edge.
    assign s_ready    = ~hold_full_q | frame_load;
    assign accept     = s_valid & s_ready;
    assign next_frame = hold_full_q ? hold_q : IDLE_PATTERN;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_load)       state_d = S_SEND;
            S_SEND:  if (last_bit && !en)  state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values; serial outputs are registered one cycle ahead.
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        dout_d        = dout_q;
        fco_d         = fco_q;
        dco_d         = dco_q;
        frame_start_d = frame_start_q;
        busy_d        = busy_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        underrun_d    = underrun_q;

        if (frame_load) begin
            bit_cnt_d     = '0;
            dout_d        = next_frame[DATA_WIDTH-1];
            shift_d       = {next_frame[DATA_WIDTH-2:0], 1'b0};
            fco_d         = 1'b1;
            dco_d         = ~dco_q;
            frame_start_d = 1'b1;
            busy_d        = 1'b1;
        end else if ((state_q == S_SEND) && !last_bit) begin
            bit_cnt_d     = bit_cnt_q + 1'b1;
            dout_d        = shift_q[DATA_WIDTH-1];
            shift_d       = {shift_q[DATA_WIDTH-2:0], 1'b0};
            fco_d         = (bit_cnt_q < HALF_M1);
            dco_d         = ~dco_q;
            frame_start_d = 1'b0;
            busy_d        = 1'b1;
        end else begin
            bit_cnt_d     = '0;
            dout_d        = 1'b0;
            fco_d         = 1'b0;
            dco_d         = 1'b0;
            frame_start_d = 1'b0;
            busy_d        = 1'b0;
        end

        if (frame_load) begin
            hold_full_d = 1'b0;
            if (!hold_full_q && (underrun_q != 8'hFF)) begin
                underrun_d = underrun_q + 8'd1;
            end
        end
        if (accept) begin
            hold_d      = s_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            dout_q        <= 1'b0;
            fco_q         <= 1'b0;
            dco_q         <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            underrun_q    <= 8'd0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            dout_q        <= dout_d;
            fco_q         <= fco_d;
            dco_q         <= dco_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            underrun_q    <= underrun_d;
        end
    end

    assign dout         = dout_q;
    assign fco          = fco_q;
    assign dco          = dco_q;
    assign frame_start  = frame_start_q;
    assign busy         = busy_q;
    assign underrun_cnt = underrun_q;

endmodule
`default_nettype wire
